core_sequencer: RTL and testbench

Multi-cycle control FSM for the scalar core. It issues one-cycle `enabled` pulses to fetch, decoder, exec and mem in order and waits for each unit's `completed`. It skips the mem step for non-memory instructions and commits each instruction by pulsing the register-file write enable, updating the PC and counting retired instructions. It sits above the datapath units and is the only driver of their `enabled` inputs.

---
 rtl/core_sequencer.sv | 121 ++++++++++++
 tb/tb_core_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_sequencer: issues fetch/decode/exec/mem start pulses in order,      |
// | then retires each instruction with a write strobe and a PC update.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        o_fetch_enabled,
  input  logic        i_fetch_completed,
  output logic        o_decode_enabled,
  input  logic        i_decode_completed,
  input  logic        i_dec_is_load,
  input  logic        i_dec_is_store,
  input  logic        i_dec_writes_to_reg,
  input  logic [4:0]  i_dec_rd,
  output logic        o_exec_enabled,
  input  logic        i_exec_completed,
  input  logic [31:0] i_exec_next_pc,
  output logic        o_mem_enabled,
  input  logic        i_mem_completed,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_wd,
  output logic [31:0] o_pc,
  input  logic        i_halt_req,
  output logic        o_halted,
  output logic [31:0] o_instret
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FETCH       = 4'd1,
    S_FETCH_WAIT  = 4'd2,
    S_DECODE      = 4'd3,
    S_DECODE_WAIT = 4'd4,
    S_EXEC        = 4'd5,
    S_EXEC_WAIT   = 4'd6,
    S_MEM         = 4'd7,
    S_MEM_WAIT    = 4'd8,
    S_WB          = 4'd9,
    S_HALT        = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_writes_to_reg;
  logic [4:0]  r_rd;
  logic [31:0] r_next_pc;
  logic [31:0] r_pc;
  logic [31:0] r_instret;
  logic        w_is_mem;

  assign w_is_mem = r_is_load | r_is_store;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // completed inputs only matter in their own WAIT state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        w_next = i_halt_req ? S_HALT : S_FETCH;
      S_FETCH:       w_next = S_FETCH_WAIT;
      S_FETCH_WAIT:  if (i_fetch_completed)  w_next = S_DECODE;
      S_DECODE:      w_next = S_DECODE_WAIT;
      S_DECODE_WAIT: if (i_decode_completed) w_next = S_EXEC;
      S_EXEC:        w_next = S_EXEC_WAIT;
      S_EXEC_WAIT:   if (i_exec_completed)   w_next = w_is_mem ? S_MEM : S_WB;
      S_MEM:         w_next = S_MEM_WAIT;
      S_MEM_WAIT:    if (i_mem_completed)    w_next = S_WB;
      S_WB:          w_next = i_halt_req ? S_HALT : S_FETCH;
      S_HALT:        if (!i_halt_req)        w_next = S_FETCH;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_is_load       <= 1'b0;
      r_is_store      <= 1'b0;
      r_writes_to_reg <= 1'b0;
      r_rd            <= 5'd0;
      r_next_pc       <= 32'd0;
      r_pc            <= RESET_PC;
      r_instret       <= 32'd0;
    end else begin
      if (r_state == S_DECODE_WAIT && i_decode_completed) begin
        r_is_load       <= i_dec_is_load;
        r_is_store      <= i_dec_is_store;
        r_writes_to_reg <= i_dec_writes_to_reg;
        r_rd            <= i_dec_rd;
      end
      if (r_state == S_EXEC_WAIT && i_exec_completed)
        r_next_pc <= i_exec_next_pc;
      // PC and retire count move together on the edge leaving WB
      if (r_state == S_WB) begin
        r_pc      <= r_next_pc;
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_fetch_enabled  = (r_state == S_FETCH);
  assign o_decode_enabled = (r_state == S_DECODE);
  assign o_exec_enabled   = (r_state == S_EXEC);
  assign o_mem_enabled    = (r_state == S_MEM);
  assign o_reg_we         = (r_state == S_WB) && r_writes_to_reg && (r_rd != 5'd0);
  assign o_reg_wd         = r_rd;
  assign o_pc             = r_pc;
  assign o_halted         = (r_state == S_HALT);
  assign o_instret        = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_sequencer: drives the sequencer as the four datapath units would |
// | and checks every cycle against a per-instruction timing model.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_core_sequencer;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_enabled, fetch_completed;
  logic        decode_enabled, decode_completed;
  logic        dec_is_load, dec_is_store, dec_writes_to_reg;
  logic [4:0]  dec_rd;
  logic        exec_enabled, exec_completed;
  logic [31:0] exec_next_pc;
  logic        mem_enabled, mem_completed;
  logic        reg_we;
  logic [4:0]  reg_wd;
  logic [31:0] pc;
  logic        halt_req;
  logic        halted;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instret;

  core_sequencer #(.RESET_PC(c_RESET_PC)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .o_fetch_enabled     (fetch_enabled),
    .i_fetch_completed   (fetch_completed),
    .o_decode_enabled    (decode_enabled),
    .i_decode_completed  (decode_completed),
    .i_dec_is_load       (dec_is_load),
    .i_dec_is_store      (dec_is_store),
    .i_dec_writes_to_reg (dec_writes_to_reg),
    .i_dec_rd            (dec_rd),
    .o_exec_enabled      (exec_enabled),
    .i_exec_completed    (exec_completed),
    .i_exec_next_pc      (exec_next_pc),
    .o_mem_enabled       (mem_enabled),
    .i_mem_completed     (mem_completed),
    .o_reg_we            (reg_we),
    .o_reg_wd            (reg_wd),
    .o_pc                (pc),
    .i_halt_req          (halt_req),
    .o_halted            (halted),
    .o_instret           (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_completed   = 1'b0;
    decode_completed  = 1'b0;
    exec_completed    = 1'b0;
    mem_completed     = 1'b0;
    dec_is_load       = 1'b0;
    dec_is_store      = 1'b0;
    dec_writes_to_reg = 1'b0;
    dec_rd            = 5'd0;
    exec_next_pc      = 32'd0;
  endtask

  task automatic chk_reset_state();
    chk("rst_fetch_en",  fetch_enabled,  0);
    chk("rst_decode_en", decode_enabled, 0);
    chk("rst_exec_en",   exec_enabled,   0);
    chk("rst_mem_en",    mem_enabled,    0);
    chk("rst_reg_we",    reg_we,         0);
    chk("rst_reg_wd",    reg_wd,         0);
    chk("rst_pc",        pc,             c_RESET_PC);
    chk("rst_instret",   instret,        0);
    chk("rst_halted",    halted,         0);
  endtask

  // Called at the negedge of the first FETCH cycle. A unit with latency d
  // raises completed in its d-th WAIT cycle (d >= 1); every pulse position and
  // the WB cycle follow from those latencies by simple addition.
  task automatic run_instr(input bit ld, input bit st, input bit wtr,
                           input logic [4:0] rd, input logic [31:0] npc,
                           input int df, input int dd, input int de, input int dm,
                           input bit hreq, input int abort_at);
    int pd, pe, pm, len;
    bit mem;
    mem = ld | st;
    pd  = df + 1;
    pe  = pd + dd + 1;
    pm  = pe + de + 1;
    len = mem ? (pm + dm + 2) : (pe + de + 2);
    for (int k = 0; k < len; k++) begin
      chk("fetch_en",  fetch_enabled,  32'(k == 0));
      chk("decode_en", decode_enabled, 32'(k == pd));
      chk("exec_en",   exec_enabled,   32'(k == pe));
      chk("mem_en",    mem_enabled,    32'(mem && k == pm));
      chk("reg_we",    reg_we,         32'(k == len - 1 && wtr && rd != 5'd0));
      if (k == len - 1) chk("reg_wd", reg_wd, 32'(rd));
      chk("pc_stable", pc,      model_pc);
      chk("instret",   instret, model_instret);
      chk("halted",    halted,  0);
      if (k == abort_at) begin
        rstn = 1'b0;
        idle_inputs();
        return;
      end
      fetch_completed  = (k == df);
      decode_completed = (k == pd + dd);
      if (decode_completed) begin
        dec_is_load = ld; dec_is_store = st; dec_writes_to_reg = wtr; dec_rd = rd;
      end else begin
        dec_is_load = 1'($urandom); dec_is_store = 1'($urandom);
        dec_writes_to_reg = 1'($urandom); dec_rd = 5'($urandom);
      end
      exec_completed = (k == pe + de);
      exec_next_pc   = exec_completed ? npc : $urandom;
      mem_completed  = mem ? (k == pm + dm) : 1'($urandom);
      if (hreq && k == pe + 1) halt_req = 1'b1;
      @(negedge clk);
    end
    model_pc      = npc;
    model_instret = model_instret + 32'd1;
  endtask

  // Called at the negedge of the first HALT cycle; returns at the FETCH cycle.
  task automatic do_halt(input int n);
    for (int i = 0; i < n; i++) begin
      chk("halt_halted",   halted,        1);
      chk("halt_no_fetch", fetch_enabled, 0);
      chk("halt_reg_we",   reg_we,        0);
      chk("halt_pc",       pc,            model_pc);
      chk("halt_instret",  instret,       model_instret);
      if (i == n - 1) halt_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bit ld, st, wtr, hr;
    rstn = 1'b0;
    halt_req = 1'b0;
    idle_inputs();
    model_pc = c_RESET_PC;
    model_instret = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    rstn = 1'b1;
    @(negedge clk);

    // ADD rd=5, next_pc=4, single-cycle units
    run_instr(0, 0, 1, 5'd5, 32'h4, 1, 1, 1, 1, 0, -1);
    chk("add_pc", pc, 32'h4);
    chk("add_instret", instret, 1);
    // LW rd=3 with mem completing in the 4th MEM_WAIT cycle
    run_instr(1, 0, 1, 5'd3, 32'h8, 1, 1, 1, 4, 0, -1);
    // SW, then BEQ taken to 0x40
    run_instr(0, 1, 0, 5'd7, 32'hC, 1, 1, 1, 1, 0, -1);
    run_instr(0, 0, 0, 5'd9, 32'h40, 1, 1, 1, 1, 0, -1);
    chk("beq_pc", pc, 32'h40);
    // ADDI rd=0: retires without a write
    run_instr(0, 0, 1, 5'd0, 32'h44, 2, 1, 3, 1, 0, -1);
    // halt raised during EXEC_WAIT; instruction still retires
    run_instr(0, 0, 1, 5'd12, 32'h48, 1, 2, 3, 1, 1, -1);
    do_halt(4);

    for (int n = 0; n < 30; n++) begin
      ld  = 1'($urandom);
      st  = 1'($urandom);
      wtr = 1'($urandom);
      hr  = ($urandom_range(0, 7) == 0);
      run_instr(ld, st, wtr, 5'($urandom), $urandom,
                $urandom_range(1, 4), $urandom_range(1, 4),
                $urandom_range(1, 4), $urandom_range(1, 4), hr, -1);
      if (hr) do_halt($urandom_range(1, 3));
    end

    // reset in MEM_WAIT of a load; fetch/decode/exec single-cycle -> MEM at 6
    run_instr(1, 0, 1, 5'd3, 32'h1234, 1, 1, 1, 4, 0, 8);
    @(negedge clk);
    chk_reset_state();
    model_pc = c_RESET_PC;
    model_instret = 32'd0;
    // leaving reset with halt_req high goes straight from IDLE to HALT
    halt_req = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    do_halt(3);
    run_instr(0, 0, 1, 5'd1, 32'h200, 1, 1, 1, 1, 0, -1);
    chk("post_abort_pc", pc, 32'h200);
    chk("post_abort_instret", instret, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
